// File: rtl/tsp_pkg.sv
// Shared constants and helpers for the add/sub pipeline issue controller.
package tsp_pkg;

    // Register stages between pipe_op*_o and pipe_res_i in the attached pipeline.
    localparam int unsigned TSP_LATENCY = 2;
    localparam int unsigned TSP_DWIDTH  = 8;

    typedef logic [TSP_DWIDTH-1:0] tsp_data_t;

    // Width of a counter able to hold the values 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tsp_result_fifo.sv
// First-word fall-through result buffer; head reads as zero while empty.
module tsp_result_fifo
    import tsp_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DWIDTH-1:0]         push_data,
    input  logic                      pop,
    output logic [DWIDTH-1:0]         head,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule

// File: rtl/tsp_issue_ctrl.sv
// Issue/return flow control around a fixed-latency, non-stallable add/sub pipeline.
module tsp_issue_ctrl
    import tsp_pkg::*;
#(
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned LATENCY = TSP_LATENCY,
    parameter int unsigned DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DWIDTH-1:0] in_op1_i,
    input  logic [DWIDTH-1:0] in_op2_i,
    output logic [DWIDTH-1:0] pipe_op1_o,
    output logic [DWIDTH-1:0] pipe_op2_o,
    input  logic [DWIDTH-1:0] pipe_res_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_res_o,
    output logic              busy_o
);

    localparam int unsigned CW = cnt_w(DEPTH);

    logic [CW-1:0]      credits_q, credits_d;
    logic [LATENCY-1:0] vld_q;
    logic               issue;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;

    // A credit covers one slot either in flight or buffered, so a returning
    // result always has a FIFO entry waiting for it.
    assign in_ready_o  = (credits_q != '0);
    assign issue       = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign out_valid_o = !fifo_empty;

    // Idle cycles feed zeros to the pipeline.
    assign pipe_op1_o = issue ? in_op1_i : '0;
    assign pipe_op2_o = issue ? in_op2_i : '0;

    assign busy_o = (|vld_q) || (fifo_count != '0);

    // Credit next-state: issue consumes, pop returns, both together cancel.
    always_comb begin
        credits_d = credits_q;
        case ({issue, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    // Credit counter and in-flight tag shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits_q <= CW'(DEPTH);
            vld_q     <= '0;
        end else begin
            credits_q <= credits_d;
            vld_q[0]  <= issue;
            for (int k = 1; k < int'(LATENCY); k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    tsp_result_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_q[LATENCY-1]),
        .push_data (pipe_res_i),
        .pop       (pop),
        .head      (out_res_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_credit_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(issue && !pop && credits_q == '0));
    a_credit_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(pop && !issue && credits_q == CW'(DEPTH)));
    a_push_into_full: assert property (@(posedge clk) disable iff (!rst)
        !(vld_q[LATENCY-1] && fifo_full && !pop));

endmodule
